// File: rtl/three_input_or_checker_pkg.sv
// Shared types and sizing for the three-input OR gate checker.
// Holds the sweep FSM state encoding and the vector/counter widths.
package or_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int ERR_W       = 4;

endpackage

// File: rtl/three_input_or_checker_or3_ref_model.sv
// Golden model of the OR gate under test: d_exp = a|b, e_exp = a|b|c.
// Purely combinational so benches can reuse it as a reference.
module or3_ref_model (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d_exp,
    output logic e_exp
);

    assign d_exp = a | b;
    assign e_exp = a | b | c;

endmodule

// File: rtl/three_input_or_checker.sv
// Sweeps all 8 input vectors through an external OR3 gate and counts mismatching vectors.
// Per-vector fail_mask register is built only when OR_CHK_FAIL_MASK_EN is defined.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// DRIVE  | vector idx on a/b/c, settle counter running
// SAMPLE | compare d/e against the reference on this edge
// DONE   | results held, a/b/c = 111, start restarts the sweep
module three_input_or_checker
    import or_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   a,
    output logic                   b,
    output logic                   c,
    input  logic                   d,
    input  logic                   e,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_W-1:0]       err_cnt,
    output logic [NUM_VECTORS-1:0] fail_mask
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("SETTLE_CYCLES must be within 1..15");
        end
    endgenerate

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_VECTORS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              d_exp;
    logic              e_exp;
    logic              vec_bad;

    // The stimulus register is the vector index itself: a=idx[2], b=idx[1], c=idx[0].
    or3_ref_model u_ref (
        .a     (idx_q[2]),
        .b     (idx_q[1]),
        .c     (idx_q[0]),
        .d_exp (d_exp),
        .e_exp (e_exp)
    );

    assign vec_bad = (d != d_exp) || (e != e_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                end
            end
            ST_DRIVE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                // At most 8 increments, so the 4-bit count cannot wrap.
                if (vec_bad) begin
                    err_d = err_q + ERR_W'(1);
                end
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = '0;
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef OR_CHK_FAIL_MASK_EN
    logic [NUM_VECTORS-1:0] mask_q;
    logic                   mask_clr;
    logic                   mask_set;

    assign mask_clr = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
    assign mask_set = (state_q == ST_SAMPLE) && vec_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
        end else if (mask_clr) begin
            mask_q <= '0;
        end else if (mask_set) begin
            mask_q[idx_q] <= 1'b1;
        end
    end

    assign fail_mask = mask_q;
`else
    assign fail_mask = '0;
`endif

    assign a       = idx_q[2];
    assign b       = idx_q[1];
    assign c       = idx_q[0];
    assign busy    = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done    = (state_q == ST_DONE);
    assign pass    = done && (err_q == '0);
    assign err_cnt = err_q;

endmodule

// File: tb/tb_three_input_or_checker.sv
// Bench for three_input_or_checker: fault-injectable gate model, random fault patterns,
// reference counts computed from the OR truth table.
module tb_three_input_or_checker;

    logic       clk = 1'b0;
    logic       rst, start, start1;
    logic       a, b, c, d, e, busy, done, pass;
    logic [3:0] err_cnt;
    logic [7:0] fail_mask;
    logic       a1, b1, c1, d1, e1, busy1, done1, pass1;
    logic [3:0] err_cnt1;
    logic [7:0] fail_mask1;
    logic [7:0] fd, fe, fd1, fe1;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    // Gate under test: a correct OR gate whose outputs are inverted for the vectors flagged in fd/fe.
    assign d  = (a | b) ^ fd[{a, b, c}];
    assign e  = (a | b | c) ^ fe[{a, b, c}];
    assign d1 = (a1 | b1) ^ fd1[{a1, b1, c1}];
    assign e1 = (a1 | b1 | c1) ^ fe1[{a1, b1, c1}];

    three_input_or_checker dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .d(d), .e(e),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_mask(fail_mask)
    );

    three_input_or_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c(c1), .d(d1), .e(e1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1), .fail_mask(fail_mask1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the truth table, apply the injected faults, count vectors that differ.
    function automatic int ref_err(input logic [7:0] fdv, input logic [7:0] fev);
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            int av  = (i >> 2) & 1;
            int bv  = (i >> 1) & 1;
            int cv  = i & 1;
            int dex = av | bv;
            int eex = av | bv | cv;
            int dg  = dex ^ int'(fdv[i]);
            int eg  = eex ^ int'(fev[i]);
            if (dg != dex || eg != eex) n++;
        end
        return n;
    endfunction

    function automatic logic [7:0] ref_mask(input logic [7:0] fdv, input logic [7:0] fev);
        logic [7:0] m = 8'h00;
`ifdef OR_CHK_FAIL_MASK_EN
        for (int i = 0; i < 8; i++) begin
            int dex = ((i >> 2) | (i >> 1)) & 1;
            int eex = (i != 0) ? 1 : 0;
            if ((dex ^ int'(fdv[i])) != dex || (eex ^ int'(fev[i])) != eex) m[i] = 1'b1;
        end
`endif
        return m;
    endfunction

    task automatic run0(input string tag, input int exp_edge);
        int         n;
        int         exp_e;
        logic [7:0] exp_m;
        exp_e = ref_err(fd, fe);
        exp_m = ref_mask(fd, fe);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy_after_e0"}, busy, 1);
        chk({tag, "_done_after_e0"}, done, 0);
        chk({tag, "_err_cleared"}, err_cnt, 0);
        n = 0;
        while (!done && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_done_edge"}, n, exp_edge);
        chk({tag, "_err_cnt"}, err_cnt, exp_e);
        chk({tag, "_fail_mask"}, fail_mask, exp_m);
        chk({tag, "_pass"}, pass, (exp_e == 0) ? 1 : 0);
        chk({tag, "_abc_done"}, {a, b, c}, 3'b111);
        chk({tag, "_busy_done"}, busy, 0);
    endtask

    task automatic run1(input string tag);
        int n;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_done_edge"}, n, 16);
        chk({tag, "_err_cnt"}, err_cnt1, ref_err(fd1, fe1));
        chk({tag, "_fail_mask"}, fail_mask1, ref_mask(fd1, fe1));
        chk({tag, "_pass"}, pass1, (ref_err(fd1, fe1) == 0) ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        fd = 8'h00; fe = 8'h00; fd1 = 8'h00; fe1 = 8'h00;
        #12;
        chk("rst_abc", {a, b, c}, 3'b000);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_mask", fail_mask, 0);
        step();
        rst = 1'b0;
        step();

        run0("good", 24);
        fd = 8'h00; fe = 8'hFE;
        run0("e_stuck0", 24);
        fd = 8'h03; fe = 8'h00;
        run0("d_stuck1", 24);

        for (int k = 0; k < 6; k++) begin
            fd = 8'($urandom());
            fe = 8'($urandom());
            if ($urandom_range(0, 3) == 0) begin
                fd = 8'h00;
                fe = 8'h00;
            end
            repeat ($urandom_range(0, 3)) step();
            run0($sformatf("rand%0d", k), 24);
        end

        // start held through a whole sweep: ignored mid-run, immediate restart from DONE
        fd = 8'h00; fe = 8'h00;
        start = 1'b1;
        step();
        n = 0;
        while (!done && n < 200) begin
            step();
            n++;
        end
        chk("hold_done_edge", n, 24);
        chk("hold_pass", pass, 1);
        step();
        chk("hold_restart_done", done, 0);
        chk("hold_restart_busy", busy, 1);
        chk("hold_restart_err", err_cnt, 0);
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            step();
            n++;
        end
        chk("hold_second_edge", n, 24);

        // reset during idx=4 DRIVE
        fd = 8'h00; fe = 8'h0F;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!({a, b, c} == 3'b100 && busy) && n < 200) begin
            step();
            n++;
        end
        chk("rst_mid_reached_idx4", ({a, b, c} == 3'b100) ? 1 : 0, 1);
        chk("rst_mid_pre_err", err_cnt, ref_err(8'h00, 8'h0F));
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_abc", {a, b, c}, 3'b000);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_err", err_cnt, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_mask", fail_mask, 0);
        #2 rst = 1'b0;
        step();
        fd = 8'h00; fe = 8'h00;
        run0("post_rst", 24);

        run1("s1_good");
        for (int k = 0; k < 3; k++) begin
            fd1 = 8'($urandom());
            fe1 = 8'($urandom());
            run1($sformatf("s1_rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
